// File: rtl/divider_8_by_4_bit.sv
// ============================================================================
// Module   : divider_8_by_4_bit
// Brief    : Sequential 8-bit by 4-bit unsigned restoring divider, one
//            quotient bit per clock, with divide-by-zero detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_8_by_4_bit (
    input  logic       Clk_In,
    input  logic       Reset_n_In,
    input  logic       Start_In,
    input  logic [7:0] Data_A_In,
    input  logic [3:0] Data_B_In,
    output logic [7:0] Quotient_Out,
    output logic [3:0] Remainder_Out,
    output logic       Busy_Out,
    output logic       Done_Out,
    output logic       Div_By_Zero_Out
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DIVIDE = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next_state;

    logic [7:0] r_dividend;
    logic [3:0] r_divisor;
    logic [2:0] r_cnt;
    logic [4:0] r_rem;
    logic [7:0] r_quo;

    logic [7:0] r_quotient_out;
    logic [3:0] r_remainder_out;
    logic       r_dbz_out;

    logic [4:0] w_rem_shift;
    logic       w_rem_ge;
    logic [4:0] w_rem_next;
    logic [7:0] w_quo_next;

    // 5-bit partial remainder: a value below 15 shifted left still fits.
    assign w_rem_shift = {r_rem[3:0], r_dividend[7]};
    assign w_rem_ge    = (w_rem_shift >= {1'b0, r_divisor});
    assign w_rem_next  = w_rem_ge ? (w_rem_shift - {1'b0, r_divisor}) : w_rem_shift;
    assign w_quo_next  = {r_quo[6:0], w_rem_ge};

    always_ff @(posedge Clk_In) begin
        if (!Reset_n_In) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (Start_In) begin
                    w_next_state = (Data_B_In == 4'd0) ? c_DONE : c_DIVIDE;
                end
            end
            c_DIVIDE: begin
                if (r_cnt == 3'd7) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        Busy_Out = (r_state != c_IDLE);
        Done_Out = (r_state == c_DONE);
    end

    always_ff @(posedge Clk_In) begin
        if (!Reset_n_In) begin
            r_dividend      <= 8'd0;
            r_divisor       <= 4'd0;
            r_cnt           <= 3'd0;
            r_rem           <= 5'd0;
            r_quo           <= 8'd0;
            r_quotient_out  <= 8'd0;
            r_remainder_out <= 4'd0;
            r_dbz_out       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (Start_In) begin
                        r_dividend <= Data_A_In;
                        r_divisor  <= Data_B_In;
                        r_cnt      <= 3'd0;
                        r_rem      <= 5'd0;
                        r_quo      <= 8'd0;
                        if (Data_B_In == 4'd0) begin
                            r_quotient_out  <= 8'hFF;
                            r_remainder_out <= 4'hF;
                            r_dbz_out       <= 1'b1;
                        end
                    end
                end
                c_DIVIDE: begin
                    r_dividend <= {r_dividend[6:0], 1'b0};
                    r_rem      <= w_rem_next;
                    r_quo      <= w_quo_next;
                    r_cnt      <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_quotient_out  <= w_quo_next;
                        r_remainder_out <= w_rem_next[3:0];
                        r_dbz_out       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Quotient_Out    = r_quotient_out;
    assign Remainder_Out   = r_remainder_out;
    assign Div_By_Zero_Out = r_dbz_out;

endmodule

`default_nettype wire

// File: tb/tb_divider_8_by_4_bit.sv
// ============================================================================
// Module   : tb_divider_8_by_4_bit
// Brief    : Directed and random checks of the 8-by-4 divider against a
//            cycle-count behavioural model plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider_8_by_4_bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [3:0] b_in;
    logic [7:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    divider_8_by_4_bit dut (
        .Clk_In          (clk),
        .Reset_n_In      (rst_n),
        .Start_In        (start),
        .Data_A_In       (a_in),
        .Data_B_In       (b_in),
        .Quotient_Out    (q),
        .Remainder_Out   (r),
        .Busy_Out        (busy),
        .Done_Out        (done),
        .Div_By_Zero_Out (err)
    );

    // Model: m_left counts the busy cycles still to come; the last one is Done.
    int         m_left = 0;
    logic [7:0] m_a = 8'd0;
    logic [3:0] m_b = 4'd0;
    logic [7:0] m_q = 8'd0;
    logic [3:0] m_r = 4'd0;
    logic       m_e = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0;
            m_q    = 8'd0;
            m_r    = 4'd0;
            m_e    = 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                m_a = a_in;
                m_b = b_in;
                if (b_in == 4'd0) begin
                    m_left = 1;
                    m_q    = 8'hFF;
                    m_r    = 4'hF;
                    m_e    = 1'b1;
                end else begin
                    m_left = 9;
                end
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 1) begin
                m_q = m_a / m_b;
                m_r = m_a % m_b;
                m_e = 1'b0;
            end
        end
        #1;
        total++;
        if ({busy, done, q, r, err} !== {(m_left != 0), (m_left == 1), m_q, m_r, m_e}) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t: got busy=%b done=%b q=%0d r=%0d err=%b, want busy=%b done=%b q=%0d r=%0d err=%b",
                     $time, busy, done, q, r, err, (m_left != 0), (m_left == 1), m_q, m_r, m_e);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] av, input logic [3:0] bv,
                          input int eq, input int er, input int ee,
                          input int elat, input string nm);
        int lat;
        int bc;
        @(negedge clk);
        start = 1'b1;
        a_in  = av;
        b_in  = bv;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        bc  = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) bc++;
        end
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_busy_cycles"}, bc, elat);
        chk({nm, "_q"}, int'(q), eq);
        chk({nm, "_r"}, int'(r), er);
        chk({nm, "_err"}, int'(err), ee);
        @(negedge clk);
    endtask

    initial begin
        int ndone;
        int ra;
        int rb;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = 8'd0;
        b_in  = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst_n = 1'b1;

        run_op(8'd200, 4'd13, 15, 5, 0, 9, "a200_b13");
        run_op(8'd255, 4'd1, 255, 0, 0, 9, "a255_b1");
        run_op(8'd7, 4'd15, 0, 7, 0, 9, "a7_b15");
        run_op(8'd0, 4'd9, 0, 0, 0, 9, "a0_b9");
        run_op(8'd255, 4'd15, 17, 0, 0, 9, "a255_b15");
        run_op(8'd100, 4'd0, 255, 15, 1, 1, "a100_b0");
        run_op(8'd100, 4'd10, 10, 0, 0, 9, "a100_b10");

        // Start held high, operands changed while dividing.
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'd200;
        b_in  = 4'd13;
        ndone = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            a_in = 8'd45;
            b_in = 4'd6;
            if (done) ndone++;
        end
        chk("held_done_count", ndone, 1);
        chk("held_q", int'(q), 15);
        chk("held_r", int'(r), 5);
        @(negedge clk);
        chk("held_idle_after_done", int'(busy), 0);
        @(negedge clk);
        chk("held_reaccept", int'(busy), 1);
        start = 1'b0;
        ndone = 0;
        for (int i = 2; i <= 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("held2_done_count", ndone, 1);
        chk("held2_q", int'(q), 7);
        chk("held2_r", int'(r), 3);

        // Reset asserted at edge 4 of a division.
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'd200;
        b_in  = 4'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_q", int'(q), 0);
        chk("rst_mid_r", int'(r), 0);
        chk("rst_mid_err", int'(err), 0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_mid_no_done", ndone, 0);
        run_op(8'd45, 4'd6, 7, 3, 0, 9, "a45_b6");

        for (int i = 0; i < 60; i++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 15);
            if (rb == 0)
                run_op(8'(ra), 4'(rb), 255, 15, 1, 1, "rand");
            else
                run_op(8'(ra), 4'(rb), ra / rb, ra % rb, 0, 9, "rand");
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/divider_8_by_4_bit.md
DIVIDER_8_BY_4_BIT -- requirements
Module: Divider_8_By_4_Bit

Interface
REQ-001 SHALL have ports: Clk_In  in  1  sole clock; all logic on rising edge.
REQ-002 SHALL have ports: Reset_n_In  in  1  reset; synchronous, active-low.
REQ-003 SHALL have ports: Start_In  in  1  request to begin one division.
REQ-004 SHALL have ports: Data_A_In  in  8  dividend, unsigned.
REQ-005 SHALL have ports: Data_B_In  in  4  divisor, unsigned.
REQ-006 SHALL have ports: Quotient_Out  out  8  unsigned quotient, registered.
REQ-007 SHALL have ports: Remainder_Out  out  4  unsigned remainder, registered.
REQ-008 SHALL have ports: Busy_Out  out  1  high whenever state is not IDLE.
REQ-009 SHALL have ports: Done_Out  out  1  one-cycle pulse marking a valid result.
REQ-010 SHALL have ports: Div_By_Zero_Out  out  1  error flag for the latest result.

Function
REQ-011 SHALL implement an FSM with states IDLE, DIVIDE and DONE.
REQ-012 SHALL accept Start_In only when sampled high in IDLE; the accepting edge is edge 0.
REQ-013 SHALL capture Data_A_In and Data_B_In at edge 0; later input changes SHALL have no effect on that operation.
REQ-014 SHALL ignore Start_In in DIVIDE and DONE, with no queuing and no restart.
REQ-015 SHALL, when the captured divisor is nonzero, transition IDLE->DIVIDE at edge 0 and clear a 3-bit iteration counter and a 5-bit partial remainder.
REQ-016 SHALL, in DIVIDE, resolve one quotient bit per edge, MSB first (restoring algorithm):
- shift the next dividend bit into the partial remainder;
- if partial remainder >= divisor, subtract the divisor and set the quotient bit to 1;
- otherwise set the quotient bit to 0.
REQ-017 SHALL perform the 8 iterations on edges 1..8, then transition DIVIDE->DONE at edge 8.
REQ-018 SHALL, at edge 8, load Quotient_Out = A/B, load Remainder_Out = A mod B, and clear Div_By_Zero_Out.
REQ-019 SHALL, when the captured divisor is zero, transition IDLE->DONE at edge 0 and load Quotient_Out=8'hFF, Remainder_Out=4'hF and Div_By_Zero_Out=1.
REQ-020 SHALL assert Done_Out for exactly the one cycle spent in DONE, then transition DONE->IDLE on the next edge.
REQ-021 SHALL give a latency from acceptance to Done_Out high of 9 cycles for a nonzero divisor and 1 cycle for a zero divisor.
REQ-022 SHALL update Quotient_Out, Remainder_Out and Div_By_Zero_Out only on entry to DONE, holding them until the next completion, including throughout a later division.
REQ-023 SHALL keep Busy_Out high in DIVIDE and DONE, so a new Start_In is accepted no earlier than the first IDLE cycle after Done_Out.
REQ-024 SHALL use internal arithmetic of at least 5 bits so that no compare/subtract overflow occurs for divisor 15 and dividend 255.

Reset
REQ-025 SHALL, on any edge with Reset_n_In low, enter IDLE and zero Quotient_Out, Remainder_Out, Busy_Out, Done_Out, Div_By_Zero_Out, the counter and the partial remainder.
REQ-026 SHALL let reset take priority over Start_In and over every state transition.
REQ-027 SHALL, when reset occurs mid-DIVIDE, abort the operation with no Done_Out pulse and leave the outputs at zero.

Verification
REQ-028 SHALL cover: A=200, B=13, Start 1 cycle -> Busy high for 9 cycles; Done pulse 9 cycles after acceptance; Q=15, R=5, err=0.
REQ-029 SHALL cover boundaries: A=255, B=1 -> Q=255, R=0; A=7, B=15 -> Q=0, R=7; A=0, B=9 -> Q=0, R=0; all with latency 9.
REQ-030 SHALL cover: A=100, B=0 -> Done 1 cycle after acceptance; Q=8'hFF, R=4'hF, err=1; a following A=100, B=10 -> Q=10, R=0, err=0.
REQ-031 SHALL cover: Start held high with A/B changed during DIVIDE -> result matches the operands captured at edge 0; exactly one Done per accepted start; a new start is accepted in the first IDLE cycle after Done.
REQ-032 SHALL cover: Reset_n_In low at edge 4 of a division -> next cycle all outputs 0 and Busy 0; no Done; a subsequent A=45, B=6 -> Q=7, R=3.
REQ-033 SHALL cover at least 50 random A/B pairs (B may be 0), each checked against A/B and A mod B or the divide-by-zero values.
